// File: rtl/add_sub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_sub_pkg                                                  |
// | Description : Shared constants for the pipelined add/subtract unit:        |
// |               status flag bit positions and operation encoding.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package add_sub_pkg;

  // Bit positions inside the {N, Z, C, V} status flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Operation select encoding on sub_i
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : add_sub_pkg
`default_nettype wire

// File: rtl/add_sub_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_sub_chunk                                                |
// | Description : Combinational CW-bit adder slice with carry-in. Produces     |
// |               the slice sum, carry-out and the carry into the slice MSB    |
// |               (the latter feeds the signed-overflow flag).                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module add_sub_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_cmsb
);

  logic [CW:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_cin};
  assign o_sum  = w_full[CW-1:0];
  assign o_cout = w_full[CW];
  // The carry that entered the MSB is recovered from the MSB sum bit itself,
  // which also works for single-bit slices.
  assign o_cmsb = i_a[CW-1] ^ i_b[CW-1] ^ w_full[CW-1];

endmodule : add_sub_chunk
`default_nettype wire

// File: rtl/add_sub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_sub_pipe                                                 |
// | Description : Pipelined two's-complement add/subtract unit. The WIDTH-bit  |
// |               carry chain is split into STAGES slices, one per stage, with |
// |               a registered carry hand-off, valid/ready flow control and    |
// |               {N,Z,C,V} status flags.                                      |
// |               Optional macro ADD_SUB_PIPE_SAT_EN: saturate on overflow.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage registers: operand skew (A, inverted-B), partial result de-skew,
  // chunk carry hand-off and per-stage valid.
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_bx    [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_carry [STAGES];
  logic             r_vld   [STAGES];
  logic [3:0]       r_flags;

  // Per-stage inputs (from the ports for stage 0, else from the prior stage)
  logic [WIDTH-1:0] w_a_stg   [STAGES];
  logic [WIDTH-1:0] w_bx_stg  [STAGES];
  logic [WIDTH-1:0] w_sum_stg [STAGES];
  logic             w_cin_stg [STAGES];
  logic             w_vld_stg [STAGES];
  // Per-stage combinational results
  logic [WIDTH-1:0] w_sum_nxt [STAGES];
  logic             w_cout    [STAGES];
  logic             w_cmsb    [STAGES];

  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  logic             w_adv;
  logic             w_v;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flags;

  assign w_sub = (sub_i == OP_SUB);
  assign w_bx  = b_i ^ {WIDTH{w_sub}};

  // The whole pipe moves as one; it only freezes when the output is held.
  assign ready_o  = ready_i || !r_vld[LAST];
  assign w_adv    = ready_o;
  assign valid_o  = r_vld[LAST];
  assign result_o = r_sum[LAST];
  assign flags_o  = r_flags;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0]    w_csum;
    logic [WIDTH-1:0] w_merge;

    if (k == 0) begin : g_first
      assign w_a_stg[k]   = a_i;
      assign w_bx_stg[k]  = w_bx;
      assign w_sum_stg[k] = '0;
      assign w_cin_stg[k] = w_sub;
      assign w_vld_stg[k] = valid_i;
    end else begin : g_next
      assign w_a_stg[k]   = r_a[k-1];
      assign w_bx_stg[k]  = r_bx[k-1];
      assign w_sum_stg[k] = r_sum[k-1];
      assign w_cin_stg[k] = r_carry[k-1];
      assign w_vld_stg[k] = r_vld[k-1];
    end

    add_sub_chunk #(
      .CW(CW)
    ) u_chunk (
      .i_a    (w_a_stg[k][k*CW +: CW]),
      .i_b    (w_bx_stg[k][k*CW +: CW]),
      .i_cin  (w_cin_stg[k]),
      .o_sum  (w_csum),
      .o_cout (w_cout[k]),
      .o_cmsb (w_cmsb[k])
    );

    // Drop this stage's sum slice into the partial result carried along
    always_comb begin
      w_merge = w_sum_stg[k];
      w_merge[k*CW +: CW] = w_csum;
    end

    assign w_sum_nxt[k] = w_merge;
  end : g_stage

  assign w_v = w_cout[LAST] ^ w_cmsb[LAST];

`ifdef ADD_SUB_PIPE_SAT_EN
  // Clamp to the extreme of A's sign when the signed result overflowed
  always_comb begin
    w_res = w_sum_nxt[LAST];
    if (w_v) begin
      w_res = w_a_stg[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_res = w_sum_nxt[LAST];
`endif

  // Status flags; N and Z describe the value actually presented
  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_C] = w_cout[LAST];
    w_flags[FLAG_V] = w_v;
  end

  // Pipeline registers: cleared on reset, advanced together when not stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]     <= '0;
        r_bx[k]    <= '0;
        r_sum[k]   <= '0;
        r_carry[k] <= 1'b0;
        r_vld[k]   <= 1'b0;
      end
      r_flags <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]     <= w_a_stg[k];
        r_bx[k]    <= w_bx_stg[k];
        r_sum[k]   <= w_sum_nxt[k];
        r_carry[k] <= w_cout[k];
        r_vld[k]   <= w_vld_stg[k];
      end
      r_sum[LAST] <= w_res;
      r_flags     <= w_flags;
    end
  end

endmodule : add_sub_pipe
`default_nettype wire
